// File: rtl/rs232_pkg.sv
// Constants, limit helpers and receiver state encoding shared by the RS232 receiver and transmitter.
package rs232_pkg;
    localparam int BAUD_FAST = 115200;
    localparam int BAUD_SLOW = 19200;
    localparam int DATA_W    = 8;
    localparam int TICK_W    = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

    // Bit time in clock cycles, integer-divided and truncated to the tick counter width.
    function automatic logic [TICK_W-1:0] limit_fast(input int clock_freq);
        int q;
        q = clock_freq / BAUD_FAST;
        return q[TICK_W-1:0];
    endfunction

    function automatic logic [TICK_W-1:0] limit_slow(input int clock_freq);
        int q;
        q = clock_freq / BAUD_SLOW;
        return q[TICK_W-1:0];
    endfunction
endpackage

// File: rtl/rs232_rx_if.sv
// Register-bus side of the RS232 receiver: received byte, ready flag and acknowledge.
// The frame_err signal exists only when RS232_RX_ERR_EN is defined.
interface rs232_rx_if;
    import rs232_pkg::*;

    logic              done;
    logic [DATA_W-1:0] data_out;
    logic              rdy;
`ifdef RS232_RX_ERR_EN
    logic              frame_err;

    modport master (output done, input data_out, input rdy, input frame_err);
    modport slave  (input done, output data_out, output rdy, output frame_err);
`else
    modport master (output done, input data_out, input rdy);
    modport slave  (input done, output data_out, output rdy);
`endif
endinterface

// File: rtl/rs232_sync2.sv
// Two-flop synchronizer for asynchronous inputs; both flops reset to 1 (idle line level).
module rs232_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/rs232_rx.sv
// RS232 receiver, 8N1 at 115200/19200 baud, mid-bit sampling, byte held with rdy until done.
// Define RS232_RX_ERR_EN to check the stop bit and provide a sticky frame_err output.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | line idle, waiting for a falling edge on rxs
// ST_START | timing half a bit to confirm the start bit at its centre
// ST_DATA  | sampling 8 data bits, LSB first, one per bit time
// ST_STOP  | sampling the stop bit; with error check, may hold for line high
module rs232_rx
    import rs232_pkg::*;
#(
    parameter int clock_freq = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fsel,
    input  logic       rxd,
    rs232_rx_if.slave  bus
);
    localparam logic [TICK_W-1:0] LIM_FAST = limit_fast(clock_freq);
    localparam logic [TICK_W-1:0] LIM_SLOW = limit_slow(clock_freq);

    rx_state_t         state, state_nxt;
    logic              rxs, rxs_prev;
    logic              fsel_q;
    logic [TICK_W-1:0] tick;
    logic [TICK_W-1:0] limit, half, target;
    logic              tc;
    logic [2:0]        bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] data_q;
    logic              rdy_q;
    logic              start_det, shift_en, deliver;

    rs232_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxs)
    );

    assign limit  = fsel_q ? LIM_SLOW : LIM_FAST;
    assign half   = {1'b0, limit[TICK_W-1:1]};
    assign target = (state == ST_START) ? half : limit;
    // Wrapping one count early gives a period of exactly `target` cycles.
    assign tc     = (tick == target - {{(TICK_W-1){1'b0}}, 1'b1});

`ifdef RS232_RX_ERR_EN
    logic err_q, err_hold, set_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_det = 1'b0;
        shift_en  = 1'b0;
        deliver   = 1'b0;
`ifdef RS232_RX_ERR_EN
        set_err   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (rxs_prev && !rxs) begin
                    start_det = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (tc) state_nxt = rxs ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (tc) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
`ifdef RS232_RX_ERR_EN
                // After a bad stop bit, wait out the low line so a break is not seen as a new start.
                if (err_hold) begin
                    if (rxs) state_nxt = ST_IDLE;
                end else if (tc) begin
                    if (rxs) begin
                        deliver   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        set_err   = 1'b1;
                    end
                end
`else
                if (tc) begin
                    deliver   = 1'b1;
                    state_nxt = ST_IDLE;
                end
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxs_prev <= 1'b1;
            fsel_q   <= 1'b0;
            tick     <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            data_q   <= '0;
            rdy_q    <= 1'b0;
        end else begin
            rxs_prev <= rxs;
            if (start_det) fsel_q <= fsel;

            if (state == ST_IDLE || tc) tick <= '0;
            else                        tick <= tick + {{(TICK_W-1){1'b0}}, 1'b1};

            if (state != ST_DATA) bit_cnt <= '0;
            else if (shift_en)    bit_cnt <= bit_cnt + 3'd1;

            if (shift_en) shreg <= {rxs, shreg[DATA_W-1:1]};
            if (deliver)  data_q <= shreg;

            // Delivery wins over an acknowledge landing in the same cycle.
            if (deliver)       rdy_q <= 1'b1;
            else if (bus.done) rdy_q <= 1'b0;
        end
    end

`ifdef RS232_RX_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q    <= 1'b0;
            err_hold <= 1'b0;
        end else begin
            if (set_err)       err_q <= 1'b1;
            else if (bus.done) err_q <= 1'b0;

            if (set_err)                     err_hold <= 1'b1;
            else if (state_nxt == ST_IDLE)   err_hold <= 1'b0;
        end
    end

    assign bus.frame_err = err_q;
`endif

    assign bus.data_out = data_q;
    assign bus.rdy      = rdy_q;
endmodule

// File: tb/tb_rs232_rx.sv
// Self-checking bench for rs232_rx: directed vector table, multi-cycle corner sequences, random frames.
module tb_rs232_rx;
    import rs232_pkg::*;

    localparam int CF = 1152000;
    localparam int LF = 10;
    localparam int LS = 60;

    logic clk = 1'b0;
    logic rst, fsel, rxd;

    rs232_rx_if bus();

    rs232_rx #(.clock_freq(CF)) dut (
        .clk  (clk),
        .rst  (rst),
        .fsel (fsel),
        .rxd  (rxd),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = -1;
    logic rdy_d = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rdy === 1'b1 && rdy_d !== 1'b1) rise_cyc = cyc;
        rdy_d = bus.rdy;
    end

    initial begin
        #(300000 * 10);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Behavioural model: what software should see on the bus after each frame / acknowledge.
    logic [7:0] m_data;
    bit         m_rdy, m_err;

    task automatic model_reset();
        m_data = 8'h00; m_rdy = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] d, input bit stop_ok);
`ifdef RS232_RX_ERR_EN
        if (!stop_ok) begin
            m_err = 1'b1;
            return;
        end
`endif
        m_data = d;
        m_rdy  = 1'b1;
    endtask

    task automatic model_done();
        m_rdy = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_data"}, {24'h0, bus.data_out}, {24'h0, m_data});
        check({tag, "_rdy"}, {31'h0, bus.rdy}, {31'h0, m_rdy});
`ifdef RS232_RX_ERR_EN
        check({tag, "_err"}, {31'h0, bus.frame_err}, {31'h0, m_err});
`endif
    endtask

    // Drive one 8N1 frame; fsel is flipped after the start bit to show it is ignored mid-frame.
    task automatic send_frame(input logic [7:0] d, input bit fs, input bit stop_bit);
        int l;
        logic [9:0] bits;
        l = fs ? LS : LF;
        bits = {stop_bit, d, 1'b0};
        fsel = fs;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            rxd = bits[i];
            if (i == 0) start_cyc = cyc;
            if (i == 1) fsel = ~fs;
            repeat (l - 1) @(posedge clk);
        end
        @(posedge clk); #1;
        rxd  = 1'b1;
        fsel = fs;
    endtask

    task automatic pulse_done();
        @(posedge clk); #1;
        bus.done = 1'b1;
        @(posedge clk); #1;
        bus.done = 1'b0;
        model_done();
    endtask

    typedef struct {
        logic [7:0] data;
        bit         fs;
        bit         stop;
        bit         ack;
        logic [7:0] exp_data;
        bit         exp_rdy;
        bit         exp_err;
        int         exp_lat;
    } vec_t;

    localparam int NV = 7;
    vec_t vec[NV];

    initial begin
        // latency = 2 sync + half + 9*limit + 1 : 98 at 10-cycle bits, 573 at 60-cycle bits
        vec[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 98};
        vec[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 573};
        vec[2] = '{8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 98};
`ifdef RS232_RX_ERR_EN
        vec[3] = '{8'h7E, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 0};
`else
        vec[3] = '{8'h7E, 1'b0, 1'b0, 1'b1, 8'h7E, 1'b1, 1'b0, 98};
`endif
        vec[4] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 98};
        vec[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 0};
        vec[6] = '{8'h96, 1'b0, 1'b1, 1'b1, 8'h96, 1'b1, 1'b0, 98};

        rst = 1'b1; rxd = 1'b1; fsel = 1'b0; bus.done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("reset_data", {24'h0, bus.data_out}, 32'h0);
        check("reset_rdy", {31'h0, bus.rdy}, 32'h0);
`ifdef RS232_RX_ERR_EN
        check("reset_err", {31'h0, bus.frame_err}, 32'h0);
`endif

        for (int r = 0; r < NV; r++) begin
            rise_cyc = -1;
            send_frame(vec[r].data, vec[r].fs, vec[r].stop);
            model_frame(vec[r].data, vec[r].stop);
            repeat (4) @(negedge clk);
            check("vec_data", {24'h0, bus.data_out}, {24'h0, vec[r].exp_data});
            check("vec_rdy", {31'h0, bus.rdy}, {31'h0, vec[r].exp_rdy});
`ifdef RS232_RX_ERR_EN
            check("vec_err", {31'h0, bus.frame_err}, {31'h0, vec[r].exp_err});
`endif
            if (vec[r].exp_lat != 0)
                check("rdy_latency", rise_cyc - start_cyc, vec[r].exp_lat);
            if (vec[r].ack) begin
                pulse_done();
                @(negedge clk);
                check("ack_rdy", {31'h0, bus.rdy}, 32'h0);
`ifdef RS232_RX_ERR_EN
                check("ack_err", {31'h0, bus.frame_err}, 32'h0);
`endif
            end
        end

        // 3-cycle glitch must not produce a byte; the following frame must be clean.
        @(posedge clk); #1 rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (30) @(negedge clk);
        check_model("glitch");
        send_frame(8'h01, 1'b0, 1'b1);
        model_frame(8'h01, 1'b1);
        repeat (4) @(negedge clk);
        check_model("after_glitch");
        pulse_done();

        // Back-to-back frames; done coincides with delivery of the second.
        send_frame(8'h11, 1'b0, 1'b1);
        model_frame(8'h11, 1'b1);
        fork
            send_frame(8'h22, 1'b0, 1'b1);
            begin
                repeat (98) @(posedge clk);
                #1 bus.done = 1'b1;
                @(posedge clk);
                #1 bus.done = 1'b0;
            end
        join
        model_done();
        model_frame(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        check_model("b2b_done_same_cycle");

        // Reset at the start of data bit 4 aborts the frame.
        @(posedge clk); #1 rxd = 1'b0;
        repeat (LF - 1) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 rxd = i[0];
            repeat (LF - 1) @(posedge clk);
        end
        @(posedge clk); #1 rst = 1'b1; rxd = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_model("mid_reset");
        repeat (120) @(negedge clk);
        check_model("post_reset_idle");
        send_frame(8'hC3, 1'b0, 1'b1);
        model_frame(8'hC3, 1'b1);
        repeat (4) @(negedge clk);
        check_model("post_reset_frame");

        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            bit fs, st;
            d  = 8'($urandom_range(0, 255));
            fs = ($urandom_range(0, 4) == 0);
            st = ($urandom_range(0, 5) != 0);
            send_frame(d, fs, st);
            model_frame(d, st);
            repeat (4 + $urandom_range(0, 3)) @(negedge clk);
            check_model("rand");
            if ($urandom_range(0, 1) == 1) begin
                pulse_done();
                @(negedge clk);
                check_model("rand_ack");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
